// File: rtl/mole_round_scheduler_pkg.sv
// Shared types and helpers for the mole round scheduler.
//   sched_state_t : round sequencing states
//   sched_out_t   : bundle of registered scheduler outputs
//   seg_pick()    : maps an LFSR value to a segment 0..6, never repeating the previous one
package whack_pkg;

   typedef enum logic [1:0] {IDLE, GAP, ACTIVE, DONE} sched_state_t;

   localparam int SEG_COUNT = 7;

   typedef struct packed {
      logic       spawn;
      logic       mole_active;
      logic [2:0] target_seg;
      logic       miss;
      logic [3:0] level;
      logic [7:0] miss_cnt;
      logic       busy;
   } sched_out_t;

   // rnd==7 has no segment, so it folds onto 0; a repeat of the previous
   // segment is bumped to the next one, wrapping 6 -> 0.
   function automatic logic [2:0] seg_pick(input logic [2:0] rnd, input logic [2:0] prev);
      logic [2:0] cand;
      cand = (rnd == 3'd7) ? 3'd0 : rnd;
      if (cand == prev)
         cand = (cand == 3'(SEG_COUNT - 1)) ? 3'd0 : cand + 3'd1;
      return cand;
   endfunction

endpackage

// File: rtl/mole_round_scheduler_counter.sv
// Loadable down-counter that parks at zero.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val (has priority over en)
//   load_val   : value to load
//   en         : decrement by one when nonzero
//   count      : current value
//   zero       : count == 0
module load_down_counter #(
   parameter int W = 24
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         zero
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (en && (count != '0))
         count <= count - W'(1);
   end

   assign zero = (count == '0);

endmodule

// File: rtl/mole_round_scheduler.sv
// Mole round scheduler: gap -> spawn one mole -> dwell window -> hit or miss,
// with difficulty (level, shorter dwell) rising as hits accumulate.
//   clk, rst_n  : clock, async active-low reset
//   start       : 1-cycle pulse, begins a game from IDLE or DONE
//   game_end    : level from the game timer, forces DONE from GAP/ACTIVE
//   rand_seg    : LFSR value used to choose the next segment
//   hit         : 1-cycle pulse, correct button for the current mole
//   spawn       : 1-cycle pulse, new mole shown
//   mole_active : mole visible / hit window open
//   target_seg  : segment of current mole, 0..6
//   miss        : 1-cycle pulse, dwell expired without hit
//   level       : difficulty level, saturating at MAX_LEVEL
//   miss_cnt    : misses this game, saturating at 255
//   busy        : high while in GAP or ACTIVE
module mole_round_scheduler
   import whack_pkg::*;
#(
   parameter int CNT_W          = 24,
   parameter int DWELL_INIT     = 1000000,
   parameter int DWELL_STEP     = 62500,
   parameter int DWELL_MIN      = 250000,
   parameter int GAP_CYCLES     = 200000,
   parameter int HITS_PER_LEVEL = 4,
   parameter int MAX_LEVEL      = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       game_end,
   input  logic [2:0] rand_seg,
   input  logic       hit,
   output logic       spawn,
   output logic       mole_active,
   output logic [2:0] target_seg,
   output logic       miss,
   output logic [3:0] level,
   output logic [7:0] miss_cnt,
   output logic       busy
);

   localparam int HC_W = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;

   sched_state_t     state, state_nxt;
   sched_out_t       out_q, out_d;
   logic [CNT_W-1:0] dwell_cfg, dwell_cfg_nxt;
   logic [HC_W-1:0]  hit_cnt, hit_cnt_nxt;
   logic [CNT_W:0]   dwell_dec;

   logic             gap_load, gap_en, gap_zero;
   logic             dwell_load, dwell_en, dwell_zero;
   // Count values are only for debug visibility; sequencing keys off zero.
   logic [CNT_W-1:0] gap_count_unused, dwell_count_unused;

   load_down_counter #(.W(CNT_W)) u_gap (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (gap_load),
      .load_val (CNT_W'(GAP_CYCLES - 1)),
      .en       (gap_en),
      .count    (gap_count_unused),
      .zero     (gap_zero)
   );

   load_down_counter #(.W(CNT_W)) u_dwell (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (dwell_load),
      .load_val (dwell_cfg - CNT_W'(1)),
      .en       (dwell_en),
      .count    (dwell_count_unused),
      .zero     (dwell_zero)
   );

   // One extra bit so a step larger than the remaining dwell shows up as a
   // set sign bit instead of wrapping to a huge window.
   assign dwell_dec = {1'b0, dwell_cfg} - (CNT_W+1)'(DWELL_STEP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         out_q     <= '0;
         dwell_cfg <= CNT_W'(DWELL_INIT);
         hit_cnt   <= '0;
      end else begin
         state     <= state_nxt;
         out_q     <= out_d;
         dwell_cfg <= dwell_cfg_nxt;
         hit_cnt   <= hit_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt         = state;
      out_d             = out_q;
      out_d.spawn       = 1'b0;
      out_d.miss        = 1'b0;
      dwell_cfg_nxt     = dwell_cfg;
      hit_cnt_nxt       = hit_cnt;
      gap_load          = 1'b0;
      gap_en            = 1'b0;
      dwell_load        = 1'b0;
      dwell_en          = 1'b0;

      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt      = GAP;
               out_d.level    = '0;
               out_d.miss_cnt = '0;
               hit_cnt_nxt    = '0;
               dwell_cfg_nxt  = CNT_W'(DWELL_INIT);
               gap_load       = 1'b1;
            end
         end
         GAP: begin
            if (game_end) begin
               state_nxt = DONE;
            end else if (gap_zero) begin
               state_nxt         = ACTIVE;
               out_d.spawn       = 1'b1;
               out_d.mole_active = 1'b1;
               // target_seg doubles as the previous-segment memory.
               out_d.target_seg  = seg_pick(rand_seg, out_q.target_seg);
               dwell_load        = 1'b1;
            end else begin
               gap_en = 1'b1;
            end
         end
         ACTIVE: begin
            if (game_end) begin
               state_nxt         = DONE;
               out_d.mole_active = 1'b0;
            end else if (hit) begin
               // Hit is checked before expiry so a same-cycle hit wins.
               state_nxt         = GAP;
               out_d.mole_active = 1'b0;
               gap_load          = 1'b1;
               if (hit_cnt == HC_W'(HITS_PER_LEVEL - 1)) begin
                  hit_cnt_nxt = '0;
                  if (out_q.level != 4'(MAX_LEVEL))
                     out_d.level = out_q.level + 4'd1;
                  if (dwell_dec[CNT_W] || (dwell_dec < (CNT_W+1)'(DWELL_MIN)))
                     dwell_cfg_nxt = CNT_W'(DWELL_MIN);
                  else
                     dwell_cfg_nxt = dwell_dec[CNT_W-1:0];
               end else begin
                  hit_cnt_nxt = hit_cnt + HC_W'(1);
               end
            end else if (dwell_zero) begin
               state_nxt         = GAP;
               out_d.mole_active = 1'b0;
               out_d.miss        = 1'b1;
               gap_load          = 1'b1;
               if (out_q.miss_cnt != 8'hFF)
                  out_d.miss_cnt = out_q.miss_cnt + 8'd1;
            end else begin
               dwell_en = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase

      out_d.busy = (state_nxt == GAP) || (state_nxt == ACTIVE);
   end

   assign spawn       = out_q.spawn;
   assign mole_active = out_q.mole_active;
   assign target_seg  = out_q.target_seg;
   assign miss        = out_q.miss;
   assign level       = out_q.level;
   assign miss_cnt    = out_q.miss_cnt;
   assign busy        = out_q.busy;

endmodule

// File: tb/tb_mole_round_scheduler.sv
// Bench for mole_round_scheduler. Tasks predict every spawn/miss (cycle,
// segment, level, miss count) into a scoreboard; a negedge monitor pops and
// compares each event the DUT emits, and flags missing or unexpected ones.
module tb_mole_round_scheduler;

   localparam int GAP = 3, DW_INIT = 20, DW_STEP = 4, DW_MIN = 8, HPL = 2, MAXL = 15;

   logic       clk = 1'b0, rst_n = 1'b1, start = 1'b0, game_end = 1'b0, hit = 1'b0;
   logic [2:0] rand_seg = 3'd0;
   logic       spawn, mole_active, miss, busy;
   logic [2:0] target_seg;
   logic [3:0] level;
   logic [7:0] miss_cnt;

   mole_round_scheduler #(
      .CNT_W(24), .DWELL_INIT(DW_INIT), .DWELL_STEP(DW_STEP), .DWELL_MIN(DW_MIN),
      .GAP_CYCLES(GAP), .HITS_PER_LEVEL(HPL), .MAX_LEVEL(MAXL)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .game_end(game_end), .rand_seg(rand_seg),
      .hit(hit), .spawn(spawn), .mole_active(mole_active), .target_seg(target_seg),
      .miss(miss), .level(level), .miss_cnt(miss_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit         is_miss;
      int         cyc;
      logic [2:0] seg;
      logic [3:0] lvl;
      logic [7:0] mcnt;
   } ev_t;
   ev_t sb[$];

   int n_cmp = 0, n_bad = 0;

   // reference model state
   int         m_lvl = 0, m_mcnt = 0, m_hcnt = 0, m_dwell = DW_INIT, next_spawn = 0;
   logic [2:0] m_prev = 3'd0;

   function automatic logic [2:0] exp_seg(input logic [2:0] r, input logic [2:0] p);
      logic [2:0] c;
      c = (r == 3'd7) ? 3'd0 : r;
      if (c == p) c = (c == 3'd6) ? 3'd0 : c + 3'd1;
      return c;
   endfunction

   // ---------------- monitor ----------------
   ev_t me;
   always @(negedge clk) begin
      if (rst_n) begin
         while (sb.size() > 0 && sb[0].cyc < cyc) begin
            n_cmp++; n_bad++;
            $display("FAIL missing_event: no %s seen at cycle %0d (now %0d)",
                     sb[0].is_miss ? "miss" : "spawn", sb[0].cyc, cyc);
            void'(sb.pop_front());
         end
         if (spawn || miss) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_event: spawn=%b miss=%b at cycle %0d, none required",
                        spawn, miss, cyc);
            end else begin
               me = sb.pop_front();
               if (me.cyc != cyc || me.is_miss !== miss || target_seg !== me.seg ||
                   level !== me.lvl || miss_cnt !== me.mcnt) begin
                  n_bad++;
                  $display("FAIL event: got %s@%0d seg=%0d lvl=%0d mcnt=%0d, required %s@%0d seg=%0d lvl=%0d mcnt=%0d",
                           miss ? "miss" : "spawn", cyc, target_seg, level, miss_cnt,
                           me.is_miss ? "miss" : "spawn", me.cyc, me.seg, me.lvl, me.mcnt);
               end
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic push_ev(input bit is_miss, input int c, input logic [2:0] seg);
      ev_t e;
      e.is_miss = is_miss; e.cyc = c; e.seg = seg;
      e.lvl = 4'(m_lvl); e.mcnt = 8'(m_mcnt);
      sb.push_back(e);
   endtask

   // called at a negedge; returns at the negedge after the sampling edge
   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      m_lvl = 0; m_mcnt = 0; m_hcnt = 0; m_dwell = DW_INIT;
      next_spawn = cyc + GAP;
   endtask

   task automatic end_game();
      game_end = 1'b1;
      @(negedge clk);
      game_end = 1'b0;
   endtask

   // One full round. hit_at = k > 0: hit sampled k edges after spawn; 0: let it expire.
   task automatic do_round(input logic [2:0] r, input int hit_at);
      int s;
      logic [2:0] seg;
      rand_seg = r;
      s = next_spawn;
      seg = exp_seg(r, m_prev);
      m_prev = seg;
      push_ev(1'b0, s, seg);
      if (hit_at > 0) begin
         wait_until(s + hit_at - 1);
         hit = 1'b1;
         @(negedge clk);
         hit = 1'b0;
         m_hcnt++;
         if (m_hcnt == HPL) begin
            m_hcnt = 0;
            if (m_lvl < MAXL) m_lvl++;
            m_dwell = (m_dwell - DW_STEP < DW_MIN) ? DW_MIN : m_dwell - DW_STEP;
         end
         next_spawn = s + hit_at + GAP;
      end else begin
         if (m_mcnt < 255) m_mcnt++;
         push_ev(1'b1, s + m_dwell, seg);
         wait_until(s + m_dwell);
         next_spawn = s + m_dwell + GAP;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #1 rst_n = 1'b0;
      #2;
      n_cmp++;
      if ({spawn, mole_active, target_seg, miss, level, miss_cnt, busy} !== 19'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got spawn=%b act=%b seg=%0d miss=%b lvl=%0d mcnt=%0d busy=%b, required all 0",
                  spawn, mole_active, target_seg, miss, level, miss_cnt, busy);
      end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      m_prev = 3'd0;
   endtask

   task automatic test_spawn_miss();
      int s;
      logic [2:0] seg;
      pulse_start();
      n_cmp++;
      if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_in_gap: got %b, required 1", busy); end
      rand_seg = 3'd3;
      s = next_spawn;
      seg = exp_seg(3'd3, m_prev);
      m_prev = seg;
      push_ev(1'b0, s, seg);
      wait_until(s);
      n_cmp++;
      if (mole_active !== 1'b1 || busy !== 1'b1 || target_seg > 3'd6) begin
         n_bad++;
         $display("FAIL spawn_state: got act=%b busy=%b seg=%0d, required act=1 busy=1 seg<=6",
                  mole_active, busy, target_seg);
      end
      m_mcnt = 1;
      push_ev(1'b1, s + DW_INIT, seg);
      wait_until(s + DW_INIT);
      n_cmp++;
      if (miss_cnt !== 8'd1 || mole_active !== 1'b0) begin
         n_bad++;
         $display("FAIL after_miss: got mcnt=%0d act=%b, required mcnt=1 act=0", miss_cnt, mole_active);
      end
      next_spawn = s + DW_INIT + GAP;
      do_round(3'd5, 0);
   endtask

   task automatic test_game_end();
      int s;
      logic [2:0] seg;
      rand_seg = 3'd2;
      s = next_spawn;
      seg = exp_seg(3'd2, m_prev);
      m_prev = seg;
      push_ev(1'b0, s, seg);
      wait_until(s + 4);
      game_end = 1'b1;
      hit = 1'b1;                 // game_end must dominate the hit
      @(negedge clk);
      game_end = 1'b0;
      hit = 1'b0;
      n_cmp++;
      if (mole_active !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL game_end_active: got act=%b busy=%b, required 0 0", mole_active, busy);
      end
      repeat (25) @(negedge clk);   // monitor flags any late miss
      n_cmp++;
      if (level !== 4'(m_lvl) || miss_cnt !== 8'd2 || target_seg !== seg) begin
         n_bad++;
         $display("FAIL done_hold: got lvl=%0d mcnt=%0d seg=%0d, required lvl=%0d mcnt=2 seg=%0d",
                  level, miss_cnt, target_seg, m_lvl, seg);
      end
      pulse_start();
      n_cmp++;
      if (level !== 4'd0 || miss_cnt !== 8'd0 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL restart_init: got lvl=%0d mcnt=%0d busy=%b, required 0 0 1", level, miss_cnt, busy);
      end
      do_round(3'd4, 0);
   endtask

   task automatic test_levels();
      hit = 1'b1;                 // in GAP: must be ignored
      @(negedge clk);
      hit = 1'b0;
      do_round(3'($urandom_range(0, 7)), 1);
      do_round(3'($urandom_range(0, 7)), 2);
      n_cmp++;
      if (level !== 4'd1) begin n_bad++; $display("FAIL level_after_2_hits: got %0d, required 1", level); end
      do_round(3'd3, 0);          // dwell 16
      for (int i = 0; i < 3; i++) begin
         do_round(3'($urandom_range(0, 7)), 1);
         do_round(3'($urandom_range(0, 7)), 3);
         do_round(3'($urandom_range(0, 7)), 0);   // dwell 12, 8, 8
      end
      for (int i = 0; i < 28; i++) do_round(3'($urandom_range(0, 7)), 1);
      n_cmp++;
      if (level !== 4'd15) begin n_bad++; $display("FAIL level_saturate: got %0d, required 15", level); end
      do_round(3'd6, 0);
   endtask

   task automatic test_expiry_and_segs();
      end_game();
      pulse_start();
      do_round(3'd1, DW_INIT);    // hit lands on the expiry edge
      do_round(3'd2, 1);
      n_cmp++;
      if (level !== 4'd1) begin n_bad++; $display("FAIL hit_at_expiry_counted: got lvl=%0d, required 1", level); end
      do_round(3'd5, 1);
      do_round(3'd7, 1);
      n_cmp++;
      if (target_seg !== 3'd0) begin n_bad++; $display("FAIL seg_rand7: got %0d, required 0", target_seg); end
      do_round(3'd0, 1);
      n_cmp++;
      if (target_seg !== 3'd1) begin n_bad++; $display("FAIL seg_repeat_bump: got %0d, required 1", target_seg); end
      do_round(3'd6, 1);
      do_round(3'd6, 1);          // repeat of 6 wraps to 0
   endtask

   task automatic test_gap_end();
      int k;
      end_game();
      pulse_start();
      k = cyc;
      wait_until(k + GAP - 1);
      game_end = 1'b1;            // sampled on the gap-expiry edge
      @(negedge clk);
      n_cmp++;
      if (spawn !== 1'b0 || mole_active !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL gap_end_suppress: got spawn=%b act=%b busy=%b, required 0 0 0", spawn, mole_active, busy);
      end
      start = 1'b1;               // restart with game_end still high
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if (busy !== 1'b1) begin n_bad++; $display("FAIL restart_busy: got %b, required 1", busy); end
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL reenter_done: got busy=%b, required 0", busy); end
      game_end = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_reset_mid_active();
      int s;
      logic [2:0] seg;
      pulse_start();
      rand_seg = 3'd4;
      s = next_spawn;
      seg = exp_seg(3'd4, m_prev);
      push_ev(1'b0, s, seg);
      wait_until(s + 5);
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({spawn, mole_active, target_seg, miss, level, miss_cnt, busy} !== 19'd0) begin
         n_bad++;
         $display("FAIL async_reset: got act=%b seg=%0d lvl=%0d mcnt=%0d busy=%b, required all 0",
                  mole_active, target_seg, level, miss_cnt, busy);
      end
      sb.delete();
      m_prev = 3'd0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_miss_saturation();
      pulse_start();
      for (int i = 0; i < 256; i++) do_round(3'($urandom_range(0, 7)), 0);
      n_cmp++;
      if (miss_cnt !== 8'd255) begin n_bad++; $display("FAIL miss_saturate: got %0d, required 255", miss_cnt); end
   endtask

   initial begin
      test_reset();
      test_spawn_miss();
      test_game_end();
      test_levels();
      test_expiry_and_segs();
      test_gap_end();
      test_reset_mid_active();
      test_miss_saturation();
      end_game();
      for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: %0d events outstanding, required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
